// File: rtl/codma_pkg.sv
// Shared constants, descriptor layout and FSM encoding for the codma task-fetch front end.
package codma_pkg;

   localparam int unsigned MEM_DEPTH_DEF = 32;
   localparam int unsigned MEM_WIDTH_DEF = 8;
   localparam int unsigned MAX_LINKS_DEF = 4;

   localparam logic [31:0] TT_SINGLE   = 32'd0;
   localparam logic [31:0] TT_BURST    = 32'd1;
   localparam logic [31:0] TT_LINKED   = 32'd2;
   localparam logic [31:0] LINK_STRIDE = 32'd32;

   localparam logic STATUS_OK  = 1'b0;
   localparam logic STATUS_ERR = 1'b1;

   typedef struct packed {
      logic [31:0] src;
      logic [31:0] task_type;
      logic [31:0] len;
      logic [31:0] dst;
   } task_desc_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD0_W,
      ST_RD1,
      ST_RD1_W,
      ST_CHECK,
      ST_ISSUE,
      ST_WAIT_CPY,
      ST_STATUS,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      CHK_OK,
      CHK_BAD_TYPE,
      CHK_ZERO_LEN,
      CHK_LEN_ALIGN,
      CHK_SRC_RANGE,
      CHK_DST_RANGE
   } chk_cause_e;

   // The 33-bit sum keeps a carry out of bit 31 visible, so wrapped regions never pass.
   function automatic logic fits_mem(input logic [31:0] base,
                                     input logic [31:0] len,
                                     input logic [32:0] limit);
      logic [32:0] region_end;
      region_end = {1'b0, base} + {1'b0, len};
      return region_end <= limit;
   endfunction

endpackage

// File: rtl/codma_desc_check.sv
// Combinational validation of a decoded task descriptor; reports pass/fail and the first failing rule.
module codma_desc_check
   import codma_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_DEPTH_DEF * MEM_WIDTH_DEF
) (
   input  task_desc_t desc_i,
   output logic       ok_o,
   output chk_cause_e cause_o
);

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   always_comb begin
      cause_o = CHK_OK;
      if (desc_i.task_type > TT_LINKED) begin
         cause_o = CHK_BAD_TYPE;
      end else if (desc_i.len == 32'd0) begin
         cause_o = CHK_ZERO_LEN;
      end else if ((desc_i.task_type == TT_SINGLE) && (desc_i.len[2:0] != 3'd0)) begin
         cause_o = CHK_LEN_ALIGN;
      end else if ((desc_i.task_type != TT_SINGLE) && (desc_i.len[4:0] != 5'd0)) begin
         cause_o = CHK_LEN_ALIGN;
      end else if (!fits_mem(desc_i.src, desc_i.len, MEM_LIMIT)) begin
         cause_o = CHK_SRC_RANGE;
      end else if (!fits_mem(desc_i.dst, desc_i.len, MEM_LIMIT)) begin
         cause_o = CHK_DST_RANGE;
      end
      ok_o = (cause_o == CHK_OK);
   end

endmodule

// File: rtl/codma_task_fetch.sv
// Fetches and validates codma task descriptors, issues one copy command per descriptor,
// follows linked descriptors and reports completion with a status write.
module codma_task_fetch
   import codma_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
   parameter int unsigned MEM_WIDTH = MEM_WIDTH_DEF,
   parameter int unsigned MAX_LINKS = MAX_LINKS_DEF
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [31:0] task_pointer_i,
   input  logic [31:0] status_pointer_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [63:0] mem_rdata_i,
   output logic        cmd_valid_o,
   input  logic        cmd_ready_i,
   output logic [31:0] cmd_src_o,
   output logic [31:0] cmd_dst_o,
   output logic [31:0] cmd_len_o,
   output logic        cmd_burst_o,
   input  logic        cpy_done_i,
   input  logic        cpy_err_i
);

   localparam int unsigned MEM_BYTES  = MEM_DEPTH * MEM_WIDTH;
   localparam int unsigned LINK_W     = $clog2(MAX_LINKS + 1);
   localparam logic [31:0] ALIGN_MASK = 32'(MEM_WIDTH - 1);
   localparam logic [31:0] WORD_BYTES = 32'(MEM_WIDTH);

   state_e            state_q, state_d;
   logic [31:0]       ptr_q, ptr_d;
   logic [31:0]       status_ptr_q, status_ptr_d;
   task_desc_t        desc_q, desc_d;
   logic              err_q, err_d;
   logic [LINK_W-1:0] link_cnt_q, link_cnt_d;
   logic [LINK_W-1:0] link_cnt_inc;

   logic              chk_ok;
   chk_cause_e        chk_cause;
   logic              chk_pass;
   logic              status_ok;

   codma_desc_check #(
      .MEM_BYTES (MEM_BYTES)
   ) u_desc_check (
      .desc_i  (desc_q),
      .ok_o    (chk_ok),
      .cause_o (chk_cause)
   );

   assign chk_pass     = chk_ok && (chk_cause == CHK_OK);
   assign link_cnt_inc = link_cnt_q + LINK_W'(1);
   assign status_ok    = ((status_ptr_q & ALIGN_MASK) == 32'd0) && (status_ptr_q < 32'(MEM_BYTES));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q        <= '0;
         status_ptr_q <= '0;
         desc_q       <= '0;
         err_q        <= STATUS_OK;
         link_cnt_q   <= '0;
      end else begin
         ptr_q        <= ptr_d;
         status_ptr_q <= status_ptr_d;
         desc_q       <= desc_d;
         err_q        <= err_d;
         link_cnt_q   <= link_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      status_ptr_d = status_ptr_q;
      desc_d       = desc_q;
      err_d        = err_q;
      link_cnt_d   = link_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               ptr_d        = task_pointer_i;
               status_ptr_d = status_pointer_i;
               link_cnt_d   = '0;
               err_d        = STATUS_OK;
               if ((task_pointer_i & ALIGN_MASK) != 32'd0) begin
                  err_d   = STATUS_ERR;
                  state_d = ST_STATUS;
               end else begin
                  state_d = ST_RD0;
               end
            end
         end
         ST_RD0: begin
            if (mem_gnt_i) begin
               state_d = ST_RD0_W;
            end
         end
         ST_RD0_W: begin
            if (mem_rvalid_i) begin
               desc_d.task_type = mem_rdata_i[31:0];
               desc_d.src       = mem_rdata_i[63:32];
               state_d          = ST_RD1;
            end
         end
         ST_RD1: begin
            if (mem_gnt_i) begin
               state_d = ST_RD1_W;
            end
         end
         ST_RD1_W: begin
            if (mem_rvalid_i) begin
               desc_d.dst = mem_rdata_i[31:0];
               desc_d.len = mem_rdata_i[63:32];
               state_d    = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (chk_pass) begin
               state_d = ST_ISSUE;
            end else begin
               err_d   = STATUS_ERR;
               state_d = ST_STATUS;
            end
         end
         ST_ISSUE: begin
            if (cmd_ready_i) begin
               state_d = ST_WAIT_CPY;
            end
         end
         // The link counter includes the descriptor just completed, so the chain stops at MAX_LINKS copies.
         ST_WAIT_CPY: begin
            if (cpy_done_i) begin
               if (cpy_err_i) begin
                  err_d   = STATUS_ERR;
                  state_d = ST_STATUS;
               end else if (desc_q.task_type == TT_LINKED) begin
                  link_cnt_d = link_cnt_inc;
                  if (link_cnt_inc == LINK_W'(MAX_LINKS)) begin
                     err_d   = STATUS_ERR;
                     state_d = ST_STATUS;
                  end else begin
                     ptr_d   = ptr_q + LINK_STRIDE;
                     state_d = ST_RD0;
                  end
               end else begin
                  state_d = ST_STATUS;
               end
            end
         end
         ST_STATUS: begin
            if (!status_ok) begin
               err_d   = STATUS_ERR;
               state_d = ST_DONE;
            end else if (mem_gnt_i) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      busy_o      = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      cmd_valid_o = 1'b0;
      cmd_src_o   = '0;
      cmd_dst_o   = '0;
      cmd_len_o   = '0;
      cmd_burst_o = 1'b0;

      busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);

      case (state_q)
         ST_RD0: begin
            mem_req_o  = 1'b1;
            mem_addr_o = ptr_q;
         end
         ST_RD1: begin
            mem_req_o  = 1'b1;
            mem_addr_o = ptr_q + WORD_BYTES;
         end
         ST_ISSUE: begin
            cmd_valid_o = 1'b1;
            cmd_src_o   = desc_q.src;
            cmd_dst_o   = desc_q.dst;
            cmd_len_o   = desc_q.len;
            cmd_burst_o = (desc_q.task_type != TT_SINGLE);
         end
         ST_STATUS: begin
            if (status_ok) begin
               mem_req_o   = 1'b1;
               mem_we_o    = 1'b1;
               mem_addr_o  = status_ptr_q;
               mem_wdata_o = {63'b0, err_q};
            end
         end
         ST_DONE: begin
            done_o = 1'b1;
            err_o  = err_q;
         end
         default: begin
         end
      endcase
   end

endmodule
